// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity-type encoding and
// the smallest usable oversampling ratio.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int MIN_PRESCALE = 4;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser, per-bit edge counter and 3-sample majority vote.
// Decision strobe fires at ec = P/2+1; end strobe at ec = P-1.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  start,
    input  logic                  run,
    output logic                  rx_s,
    output logic                  bit_value,
    output logic                  bit_decide,
    output logic                  bit_end
);

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic [PRESCALE_W-1:0] ec_q, ec_d;
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last_ec;

    assign half    = prescale >> 1;
    assign last_ec = prescale - PRESCALE_W'(1);

    always_comb begin
        sync1_d = rx_in;
        sync2_d = sync1_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        // The falling-edge cycle is ec=0, so the first counted cycle is 1.
        if (start) begin
            ec_d = PRESCALE_W'(1);
        end else if (!run) begin
            ec_d = '0;
        end else if (ec_q == last_ec) begin
            ec_d = '0;
        end else begin
            ec_d = ec_q + PRESCALE_W'(1);
        end
        if (ec_q == half - PRESCALE_W'(1)) s0_d = sync2_q;
        if (ec_q == half)                  s1_d = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            ec_q    <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            ec_q    <= ec_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
        end
    end

    assign rx_s       = sync2_q;
    assign bit_value  = majority3(s0_q, s1_q, sync2_q);
    assign bit_decide = (ec_q == half + PRESCALE_W'(1));
    assign bit_end    = (ec_q == last_ec);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width, optional parity, one or
// two stop bits, with separate parity and framing error pulses.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP_2,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BC_W = $clog2(DATA_WIDTH + 1);

    rx_state_e             state_q, state_d;
    logic [BC_W-1:0]       bc_q, bc_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_mis_q, par_mis_d;
    logic                  stp_flag_q, stp_flag_d;
    logic                  armed_q, armed_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  stop2_q, stop2_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic rx_s;
    logic bit_value;
    logic bit_decide;
    logic bit_end;
    logic start;
    logic run;
    logic par_expect;

    // armed_q blocks re-triggering on a line that is still low after a frame.
    assign start = (state_q == IDLE) && armed_q && !rx_s &&
                   (Prescale >= PRESCALE_W'(MIN_PRESCALE));
    assign run   = (state_d == START) || (state_d == DATA) ||
                   (state_d == PARITY) || (state_d == STOP);
    assign par_expect = (par_typ_q == PAR_ODD) ? ~(^shift_q) : (^shift_q);

    uart_rx_sampler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_sampler (
        .clk       (CLK),
        .rst       (RST),
        .rx_in     (RX_IN),
        .prescale  (p_q),
        .start     (start),
        .run       (run),
        .rx_s      (rx_s),
        .bit_value (bit_value),
        .bit_decide(bit_decide),
        .bit_end   (bit_end)
    );

    always_comb begin
        state_d      = state_q;
        bc_d         = bc_q;
        shift_d      = shift_q;
        par_mis_d    = par_mis_q;
        stp_flag_d   = stp_flag_q;
        armed_d      = armed_q;
        p_d          = p_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        stop2_d      = stop2_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_s) armed_d = 1'b1;
                if (start) begin
                    state_d    = START;
                    armed_d    = 1'b0;
                    bc_d       = '0;
                    par_mis_d  = 1'b0;
                    stp_flag_d = 1'b0;
                    p_d        = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    stop2_d    = STOP_2;
                end
            end
            START: begin
                if (bit_decide && bit_value) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                    bc_d    = '0;
                end
            end
            DATA: begin
                if (bit_decide) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (bc_q == BC_W'(i)) shift_d[i] = bit_value;
                    end
                end
                if (bit_end) begin
                    if (bc_q == BC_W'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                        bc_d    = '0;
                    end else begin
                        bc_d = bc_q + BC_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_decide) par_mis_d = (bit_value != par_expect);
                if (bit_end) begin
                    state_d = STOP;
                    bc_d    = '0;
                end
            end
            STOP: begin
                if (bit_decide && !bit_value) stp_flag_d = 1'b1;
                if (stop2_q && (bc_q == '0)) begin
                    if (bit_end) bc_d = BC_W'(1);
                end else if (bit_decide) begin
                    // Leave early so a start edge right after the stop bit is seen.
                    state_d = DONE;
                    if (bit_value) armed_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!par_mis_q && !stp_flag_q) begin
                    data_valid_d = 1'b1;
                    p_data_d     = shift_q;
                end else begin
                    par_err_d = par_mis_q;
                    stp_err_d = stp_flag_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            bc_q         <= '0;
            shift_q      <= '0;
            par_mis_q    <= 1'b0;
            stp_flag_q   <= 1'b0;
            armed_q      <= 1'b0;
            p_q          <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            stop2_q      <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bc_q         <= bc_d;
            shift_q      <= shift_d;
            par_mis_q    <= par_mis_d;
            stp_flag_q   <= stp_flag_d;
            armed_q      <= armed_d;
            p_q          <= p_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            stop2_q      <= stop2_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomised frames against a frame-level outcome model;
// every output pulse is logged and compared with the expected event queue.
module tb_uart_rx_param;

    localparam int DW = 8;
    localparam int PW = 6;
    localparam int EW = DW + 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [PW-1:0] Prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          STOP_2;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    always #5 CLK = ~CLK;

    uart_rx_param #(
        .DATA_WIDTH(DW),
        .PRESCALE_W(PW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .Prescale  (Prescale),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .STOP_2    (STOP_2),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    int checks   = 0;
    int failures = 0;

    // Event = {data_valid, par_err, stp_err, P_DATA}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    logic [DW-1:0] last_good;
    logic          pulse_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && (data_valid || par_err || stp_err))
            obs_q.push_back({data_valid, par_err, stp_err, P_DATA});
        if (pulse_prev)
            check("pulse_width", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        pulse_prev = data_valid || par_err || stp_err;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1 RX_IN = 1'b1;
        end
    endtask

    task automatic drive_low(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1 RX_IN = 1'b0;
        end
    endtask

    task automatic drive_bit(input logic v, input int p, input bit glitch);
        for (int c = 0; c < p; c++) begin
            @(posedge CLK);
            #1 RX_IN = (glitch && c == p / 2) ? ~v : v;
        end
    endtask

    // Sends one frame and records the outcome the protocol rules demand.
    task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pen,
                              input logic ptyp, input logic s2, input bit bad_par,
                              input logic [1:0] stops, input int gbit, input int gap);
        logic par, pe, se, dv;
        Prescale = PW'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        STOP_2   = s2;
        par = (^d) ^ ptyp ^ bad_par;
        drive_bit(1'b0, p, 1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i], p, gbit == i);
        if (pen) drive_bit(par, p, 1'b0);
        drive_bit(stops[0], p, 1'b0);
        if (s2) drive_bit(stops[1], p, 1'b0);
        pe = pen && (par != ((^d) ^ ptyp));
        se = !stops[0] || (s2 && !stops[1]);
        dv = !pe && !se;
        if (dv) last_good = d;
        exp_q.push_back({dv, pe, se, last_good});
        idle(gap);
    endtask

    task automatic check_events(input string tag);
        repeat (4) @(posedge CLK);
        #1;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_event"}, {21'd0, obs_q.pop_front()}, {21'd0, exp_q.pop_front()});
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pdata"}, {24'd0, P_DATA}, 32'd0);
        check({tag, "_pulses"}, {29'd0, data_valid, par_err, stp_err}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [1:0]    rs;
        int            rp;

        RST = 1'b1;
        RX_IN = 1'b1;
        Prescale = PW'(8);
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        STOP_2 = 1'b0;
        last_good = '0;
        repeat (3) @(posedge CLK);
        #1 check_outputs_zero("reset");
        RST = 1'b0;
        idle(10);

        // Good frame with even parity, then bad parity keeps previous data.
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, -1, 16);
        check_events("t1_a5");
        check("t1_pdata", {24'd0, P_DATA}, 32'hA5);
        send_frame(8'h37, 8, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, -1, 16);
        check_events("t2_parerr");
        check("t2_pdata", {24'd0, P_DATA}, 32'hA5);

        // Two stop bits, second low then both high.
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, -1, 32);
        check_events("t3_stop2_bad");
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, -1, 32);
        check_events("t3_stop2_good");
        check("t3_pdata", {24'd0, P_DATA}, 32'h3C);

        // Short low glitch on idle line, then a mid-bit glitch in data.
        Prescale = PW'(8);
        drive_low(2);
        idle(20);
        check_events("t4_idle_glitch");
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 3, 16);
        check_events("t4_bit_glitch");

        // Back-to-back frames with no gap.
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, -1, 0);
        send_frame(8'hEE, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, -1, 16);
        check_events("t5_b2b");
        check("t5_pdata", {24'd0, P_DATA}, 32'hEE);

        // Prescale below minimum: line activity ignored.
        Prescale = PW'(3);
        drive_low(12);
        idle(10);
        check_events("small_prescale");

        // Break: line stays low, exactly one framing error.
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, 0);
        drive_low(60);
        idle(20);
        check_events("break");

        // Reset in the middle of data bits.
        Prescale = PW'(8);
        PAR_EN = 1'b0;
        STOP_2 = 1'b0;
        drive_bit(1'b0, 8, 1'b0);
        drive_bit(1'b1, 8, 1'b0);
        drive_bit(1'b0, 8, 1'b0);
        @(posedge CLK);
        #1 RX_IN = 1'b1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 check_outputs_zero("t6_reset");
        RST = 1'b0;
        last_good = '0;
        idle(12);
        check_events("t6_abort");
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, -1, 16);
        check_events("t6_5a");

        // Randomised frames across ratios, parity and stop configurations.
        for (int n = 0; n < 30; n++) begin
            rp = $urandom_range(4, 20);
            rd = DW'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            send_frame(rd, rp, 1'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 3) == 0, rs, $urandom_range(0, 15),
                       $urandom_range(rp, 2 * rp));
            check_events("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver: next generation of the single-width 8-bit receiver. It adds:
- configurable data width
- 2-flop input synchroniser
- 3-sample majority-vote bit decision
- one or two stop bits
- separate parity-error and framing-error flags

It sits in the RX clock domain between the serial pin and the register-file/command-parser path. It is driven by the same oversampling clock and Prescale configuration as the current receiver.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9), LSB first.
PRESCALE_W, 6, width of Prescale port; supports oversampling ratios up to 2^PRESCALE_W-1.

Ports:
CLK  input  1  oversampling clock (Prescale cycles per bit).
RST  input  1  synchronous, active-high reset.
RX_IN  input  1  asynchronous serial line, idle high.
Prescale  input  PRESCALE_W  clocks per bit; legal range 4..2^PRESCALE_W-1.
PAR_EN  input  1  1 = parity bit present after data.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
STOP_2  input  1  1 = two stop bits expected.
P_DATA  output  DATA_WIDTH  last correctly received word.
data_valid  output  1  one-cycle pulse: P_DATA updated with error-free frame.
par_err  output  1  one-cycle pulse: parity mismatch on completed frame.
stp_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (RST=1 at rising CLK): state IDLE, counters 0, synchroniser flops 1. P_DATA=0, data_valid=0, par_err=0, stp_err=0. Reset mid-frame aborts the frame with no output pulse.
- RX_IN passes 2 flops (rx_s); all logic below uses rx_s. Pin-to-rx_s latency is 2 cycles.
- Config latch: Prescale, PAR_EN, PAR_TYP and STOP_2 are captured on the IDLE->START transition. Changes mid-frame take effect on the next frame.
- Prescale < 4 at latch time: stay in IDLE, ignore line.
- Edge counter ec runs 0..P-1 per bit (P = latched Prescale). Bit counter bc counts data/stop bits.
- Majority sampling: rx_s sampled at ec = P/2-1, P/2, P/2+1 (P/2 = floor). Bit value = majority of 3. Decision is made at ec = P/2+1.
- FSM states:
  - IDLE: rx_s=0 -> START, ec=1 (the falling-edge cycle counts as ec=0).
  - START: at decision, bit=1 -> IDLE (glitch rejected, no pulses). At ec=P-1 -> DATA, ec=0, bc=0.
  - DATA: at decision, shift bit into shift register at position bc (LSB first). At ec=P-1: bc=DATA_WIDTH-1 -> PARITY if PAR_EN else STOP; otherwise bc+1.
  - PARITY: at decision, compare sampled bit with XOR(data) XOR PAR_TYP; store mismatch. At ec=P-1 -> STOP, bc=0.
  - STOP: at decision, bit=0 sets framing error. If STOP_2=1 and bc=0: at ec=P-1 go to second stop bit, bc=1. Otherwise -> DONE at the decision cycle (do not wait for ec=P-1, so a back-to-back start bit is not missed).
  - DONE (1 cycle): assert pulses, -> IDLE.
- DONE outputs (registered, visible the cycle after DONE is entered):
  - no errors: data_valid=1, P_DATA=shift register.
  - errors: par_err and/or stp_err=1, data_valid=0, P_DATA unchanged.
- Pulses are exactly one cycle wide. P_DATA holds between frames.
- Back-to-back frames: a start edge arriving ≥ P/2 cycles after the final stop decision must be received. IDLE is re-entered before that edge.
- Line held low (break): frame completes with stp_err=1. The FSM does not re-arm until rx_s is seen high in IDLE; a stuck-low line produces no repeated frames.
- Width rules: ec and the P/2 compare are PRESCALE_W bits; bc is clog2(DATA_WIDTH+1) bits.

Decomposition:
- Package uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP, DONE), parity-type constants (PAR_EVEN=0, PAR_ODD=1), MIN_PRESCALE=4. Shared with the future parametrised transmitter.
- One sub-module, uart_rx_sampler: synchroniser, edge counter and majority vote. Outputs bit_value and a bit_decide/bit_end strobe.

Test Plan:
1. DATA_WIDTH=8, P=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0, one stop -> data_valid pulse 1 cycle, P_DATA=0xA5, par_err=0, stp_err=0.
2. Same config, 0x37 sent with parity 0 (correct is 1) -> par_err=1, data_valid=0, P_DATA keeps 0xA5.
3. PAR_EN=0, STOP_2=1, P=16, 0x3C with second stop bit low -> stp_err=1, data_valid=0. Repeat with both stop bits high -> P_DATA=0x3C.
4. P=8: 2-cycle low glitch on idle line -> START rejects at decision, no pulses, back in IDLE. Single-cycle mid-bit glitch inside a data bit of 0xA5 -> majority vote masks it, P_DATA=0xA5.
5. Two back-to-back frames 0x11 then 0xEE, second start immediately after stop -> two data_valid pulses; P_DATA=0x11 then 0xEE.
6. RST pulsed during DATA of a frame, then a clean 0x5A frame -> no pulses from the aborted frame, outputs 0 after reset, then P_DATA=0x5A with data_valid.
